alu_lane_sequencer: RTL and testbench

ALU_LANE_SEQUENCER -- requirements
Module: alu_lane_sequencer

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 35 +++
 rtl/alu_lane_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_lane_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, sequencer state encoding and default geometry for the lane ALU.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_LANES     = 4;

    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Single-lane combinational ALU with zero and negative flags.
// Latency: combinational, zero cycles.
// Backpressure: none; the result follows the inputs.
module alu
    import alu_pkg::*;
#(
    parameter int dataSize = DEFAULT_DATA_SIZE
) (
    input  logic [2:0]          op,
    input  logic [dataSize-1:0] a,
    input  logic [dataSize-1:0] b,
    output logic [dataSize-1:0] result,
    output logic                zero,
    output logic                neg
);

    // Per-op result, truncated to the lane width; unused op code 000 yields zero.
    always_comb begin
        result = '0;
        case (op)
            OP_XOR:  result = a ^ b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_SHR:  result = a >> b;
            OP_SHL:  result = a << b;
            OP_INC:  result = a + 1'b1;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[dataSize-1];

endmodule

// File: rtl/alu_lane_sequencer.sv
// Runs one vector ALU operation lane by lane through a single shared alu instance.
// Latency: out_valid rises LANES rising edges after the accepting edge.
// Backpressure: results held in DONE until out_ready; in_ready only in IDLE.
module alu_lane_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int LANES     = DEFAULT_LANES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic [LANES*DATA_SIZE-1:0] vec_a,
    input  logic [LANES*DATA_SIZE-1:0] vec_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_SIZE-1:0] vec_result,
    output logic [LANES-1:0]           lane_zero,
    output logic [LANES-1:0]           lane_neg,
    output logic                       busy
);

    localparam int VW    = LANES * DATA_SIZE;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       op_q, op_d;
    logic [VW-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [LANES-1:0] zero_q, zero_d, neg_q, neg_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [DATA_SIZE-1:0] lane_a, lane_b, lane_res;
    logic                 lane_zf, lane_nf;

    // Route the captured operands of the current lane into the shared ALU.
    always_comb begin
        lane_a = a_q[int'(idx_q)*DATA_SIZE +: DATA_SIZE];
        lane_b = b_q[int'(idx_q)*DATA_SIZE +: DATA_SIZE];
    end

    alu #(
        .dataSize (DATA_SIZE)
    ) u_alu (
        .op     (op_q),
        .a      (lane_a),
        .b      (lane_b),
        .result (lane_res),
        .zero   (lane_zf),
        .neg    (lane_nf)
    );

    // Next-state: capture in IDLE, write one lane per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = vec_a;
                    b_d     = vec_b;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[int'(idx_q)*DATA_SIZE +: DATA_SIZE] = lane_res;
                zero_d[idx_q] = lane_zf;
                neg_d[idx_q]  = lane_nf;
                // Index parks on the last lane; only a new accept resets it.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and handshake flags; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            zero_q      <= '0;
            neg_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign vec_result = res_q;
    assign lane_zero  = zero_q;
    assign lane_neg   = neg_q;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Scoreboard bench: randomized requests checked against a per-lane arithmetic model.
// Latency: expects out_valid exactly LANES edges after each accept.
// Backpressure: consumer alternates between always-ready, random and a 5-cycle stall.
module tb_alu_lane_sequencer;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int LN = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [LN*DW-1:0]   vec_a, vec_b;
    logic               out_valid;
    logic               out_ready;
    logic [LN*DW-1:0]   vec_result;
    logic [LN-1:0]      lane_zero, lane_neg;
    logic               busy;

    alu_lane_sequencer #(.DATA_SIZE(DW), .LANES(LN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .vec_result (vec_result),
        .lane_zero  (lane_zero),
        .lane_neg   (lane_neg),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LN*DW-1:0] res;
        logic [LN-1:0]    z;
        logic [LN-1:0]    n;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, n_sent = 0, n_done = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    logic [LN*DW-1:0] last_res;
    logic [LN-1:0]    last_z, last_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
    endtask

    // Reference: one lane of arithmetic on plain integers, reduced mod 2^DW.
    function automatic int ref_lane(input logic [2:0] o, input int a, input int b);
        int r;
        case (o)
            3'd1: r = a ^ b;
            3'd2: r = a + b;
            3'd3: r = a + (1 << DW) - b;
            3'd4: r = a * b;
            3'd5: r = (b >= DW) ? 0 : (a / (1 << b));
            3'd6: r = (b >= DW) ? 0 : (a * (1 << b));
            3'd7: r = a + 1;
            default: r = 0;
        endcase
        return r % (1 << DW);
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [LN*DW-1:0] a,
                                   input logic [LN*DW-1:0] b);
        exp_t e;
        int   r;
        e.res = '0; e.z = '0; e.n = '0; e.acc = 0;
        for (int i = 0; i < LN; i++) begin
            r = ref_lane(o, int'(a[i*DW +: DW]), int'(b[i*DW +: DW]));
            e.res[i*DW +: DW] = DW'(r);
            e.z[i] = (r == 0);
            e.n[i] = (r >= (1 << (DW - 1)));
        end
        return e;
    endfunction

    task automatic scramble();
        in_valid = 1'($urandom_range(0, 1));
        op       = 3'($urandom_range(0, 7));
        vec_a    = $urandom;
        vec_b    = $urandom;
    endtask

    // Issue one request and wait for its completion handshake; called at posedge+1.
    task automatic send(input logic [2:0] o, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
        exp_t e;
        int   w;
        w = 0;
        while (!in_ready && w < 300) begin scramble(); @(posedge clk); #1; w++; end
        if (!in_ready) begin tmo("accept_wait"); in_valid = 1'b0; return; end
        in_valid = 1'b1; op = o; vec_a = a; vec_b = b;
        e = model(o, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        n_sent++;
        @(posedge clk); #1;
        w = 0;
        while (!in_ready && w < 300) begin scramble(); @(posedge clk); #1; w++; end
        if (!in_ready) tmo("done_wait");
        in_valid = 1'b0;
    endtask

    // Consumer: out_ready policy selected by bp_mode.
    int stall_cnt = 0;
    always begin
        @(posedge clk); #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid) stall_cnt++; else stall_cnt = 0;
                out_ready = (stall_cnt > 5);
            end
        endcase
    end

    // Monitor: compare presented results with the scoreboard head every cycle.
    logic prev_v = 1'b0, prev_hs = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("idle_after_handshake", 64'({in_ready, out_valid, busy}), 64'(3'b100));
            prev_hs = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    tmo("spurious_out_valid");
                end else begin
                    e = sb[0];
                    if (!prev_v) chk("latency", 64'(cyc), 64'(e.acc + LN));
                    chk("vec_result", 64'(vec_result), 64'(e.res));
                    chk("lane_zero", 64'(lane_zero), 64'(e.z));
                    chk("lane_neg", 64'(lane_neg), 64'(e.n));
                    chk("done_flags", 64'({in_ready, busy}), 64'(2'b01));
                    if (out_ready) begin
                        last_res = vec_result; last_z = lane_zero; last_n = lane_neg;
                        void'(sb.pop_front());
                        n_done++;
                        prev_hs = 1'b1;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] l_op [5] = '{OP_MUL, OP_SHR, OP_SHL, OP_XOR, OP_INC};
    logic [7:0] l_a  [5] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    logic [7:0] l_b  [5] = '{8'd2, 8'd1, 8'd2, 8'd2, 8'd0};
    logic [7:0] l_r  [5] = '{8'd6, 8'd1, 8'd12, 8'd1, 8'd5};

    initial begin
        logic [LN*DW-1:0] ra, rb;
        logic [2:0]       ro;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; vec_a = '0; vec_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("reset_state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        chk("reset_result", 64'({vec_result, lane_zero, lane_neg}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(OP_ADD, 32'h04030201, 32'h03030303);
        chk("add_result", 64'(last_res), 64'(32'h07060504));
        chk("add_flags", 64'({last_z, last_n}), 64'(8'b0000_0000));

        send(OP_SUB, 32'h05030100, 32'h05020300);
        chk("sub_result", 64'(last_res), 64'(32'h0001FE00));
        chk("sub_flags", 64'({last_z, last_n}), 64'(8'b1001_0010));

        for (int k = 0; k < 5; k++) begin
            ra = {24'($urandom), l_a[k]};
            rb = {24'($urandom), (l_op[k] == OP_INC) ? 8'($urandom) : l_b[k]};
            send(l_op[k], ra, rb);
            chk("lane0_op", 64'(last_res[7:0]), 64'(l_r[k]));
        end

        bp_mode = 2;
        send(OP_ADD, $urandom, $urandom);
        bp_mode = 0;

        // Abort mid-RUN: result must never be delivered.
        in_valid = 1'b1; op = OP_ADD; vec_a = 32'h11223344; vec_b = 32'h01010101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("busy_mid_run", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        chk("abort_result", 64'({vec_result, lane_zero, lane_neg}), 64'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(OP_ADD, 32'h7F00FF10, 32'h01010101);
        chk("post_reset_add", 64'(last_res), 64'(32'h80010011));

        bp_mode = 1;
        repeat (40) begin
            ro = 3'($urandom_range(1, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb & 32'h0F0F0F0F;
            send(ro, ra, rb);
        end
        bp_mode = 0;
        repeat (3) @(posedge clk); #1;

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("delivered_count", 64'(n_done), 64'(n_sent));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
